// File: rtl/column_bank_scheduler.sv
// Column store controller: packs four Avalon words into a column record and
// rotates three banks between write / pending / read roles at frame boundaries.
module column_bank_scheduler #(
  parameter int NUM_COLS = 640,
  parameter int COL_W    = 10,
  parameter int DROP_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 chipselect,
  input  logic                 write,
  input  logic                 address,
  input  logic [15:0]          writedata,
  input  logic                 frame_start,
  input  logic [COL_W-1:0]     rd_col,
  output logic [2:0]           bank_we,
  output logic [3*COL_W-1:0]   bank_addr,
  output logic [41:0]          wr_coldata,
  output logic [15:0]          wr_sfdata,
  output logic [1:0]           rd_bank,
  output logic [1:0]           wr_bank,
  output logic                 frame_ready,
  output logic [DROP_W-1:0]    dropped_frames
);

  localparam logic [1:0] S_W0 = 2'd0;
  localparam logic [1:0] S_W1 = 2'd1;
  localparam logic [1:0] S_W2 = 2'd2;
  localparam logic [1:0] S_W3 = 2'd3;

  logic [1:0]        r_state;
  logic [9:0]        r_w0;
  logic [15:0]       r_w1, r_w2;
  logic [COL_W-1:0]  r_wr_col, r_wr_addr;
  logic [2:0]        r_we;
  logic [41:0]       r_coldata;
  logic [15:0]       r_sf;
  logic [1:0]        r_rd, r_wr, r_pend;
  logic              r_ready;
  logic [DROP_W-1:0] r_drop;

  logic w_acc, w_data, w_ctrl, w_last_word, w_complete;

  assign w_acc       = chipselect && write;
  assign w_data      = w_acc && !address;
  assign w_ctrl      = w_acc && address;
  assign w_last_word = w_data && (r_state == S_W3);
  assign w_complete  = w_last_word && (r_wr_col == COL_W'(NUM_COLS - 1));

  // Word assembly; the write pulse is registered so it lands one cycle after
  // the 4th word and targets the bank that was being filled at that moment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_W0;
      r_w0      <= '0;
      r_w1      <= '0;
      r_w2      <= '0;
      r_wr_col  <= '0;
      r_wr_addr <= '0;
      r_we      <= '0;
      r_coldata <= '0;
      r_sf      <= '0;
    end else begin
      r_we <= '0;
      if (w_ctrl && writedata[0]) begin
        r_state  <= S_W0;
        r_wr_col <= '0;
      end else if (w_data) begin
        case (r_state)
          S_W0: begin r_w0 <= writedata[9:0]; r_state <= S_W1; end
          S_W1: begin r_w1 <= writedata;      r_state <= S_W2; end
          S_W2: begin r_w2 <= writedata;      r_state <= S_W3; end
          default: begin
            r_coldata <= {r_w2, r_w1, r_w0};
            r_sf      <= writedata;
            r_wr_addr <= r_wr_col;
            r_we      <= 3'b001 << r_wr;
            r_state   <= S_W0;
            r_wr_col  <= w_complete ? '0 : r_wr_col + 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd    <= 2'd0;
      r_wr    <= 2'd1;
      r_pend  <= 2'd2;
      r_ready <= 1'b0;
    end else if (w_complete && frame_start) begin
      // Freshly completed frame goes straight to display; pending stays put.
      r_rd    <= r_wr;
      r_wr    <= r_rd;
      r_ready <= 1'b0;
    end else if (w_complete) begin
      if (!r_ready) begin
        r_pend  <= r_wr;
        r_wr    <= 2'd3 ^ r_wr ^ r_rd;
        r_ready <= 1'b1;
      end else begin
        r_wr   <= r_pend;
        r_pend <= r_wr;
      end
    end else if (frame_start && r_ready) begin
      r_rd    <= r_pend;
      r_pend  <= r_rd;
      r_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop <= '0;
    else if (w_ctrl && writedata[1])
      r_drop <= '0;
    else if (w_complete && r_ready && r_drop != '1)
      r_drop <= r_drop + 1'b1;
  end

  for (genvar k = 0; k < 3; k++) begin : g_addr
    assign bank_addr[k*COL_W +: COL_W] = r_we[k]           ? r_wr_addr :
                                         (r_rd == 2'(k))   ? rd_col    : '0;
  end

  assign bank_we        = r_we;
  assign wr_coldata     = r_coldata;
  assign wr_sfdata      = r_sf;
  assign rd_bank        = r_rd;
  assign wr_bank        = r_wr;
  assign frame_ready    = r_ready;
  assign dropped_frames = r_drop;

endmodule

// File: tb/tb_column_bank_scheduler.sv
// Directed bench: vector table for single-column behaviour plus sequences for
// frame completion, swaps, drops, resync and async reset.
module tb_column_bank_scheduler;
  localparam int NUM_COLS = 640;
  localparam int COL_W    = 10;
  localparam int DROP_W   = 8;

  logic clk = 0, reset = 1;
  logic chipselect = 0, write = 0, address = 0, frame_start = 0;
  logic [15:0] writedata = 0;
  logic [COL_W-1:0] rd_col = 10'd5;
  logic [2:0] bank_we;
  logic [3*COL_W-1:0] bank_addr;
  logic [41:0] wr_coldata;
  logic [15:0] wr_sfdata;
  logic [1:0] rd_bank, wr_bank;
  logic frame_ready;
  logic [DROP_W-1:0] dropped_frames;

  int checks = 0, errors = 0;

  column_bank_scheduler #(.NUM_COLS(NUM_COLS), .COL_W(COL_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .frame_start(frame_start),
    .rd_col(rd_col), .bank_we(bank_we), .bank_addr(bank_addr),
    .wr_coldata(wr_coldata), .wr_sfdata(wr_sfdata), .rd_bank(rd_bank),
    .wr_bank(wr_bank), .frame_ready(frame_ready), .dropped_frames(dropped_frames));

  always #10 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        a;
    logic [15:0] d;
    logic        fs;
    logic [2:0]  we;
    logic [1:0]  rd, wr;
    logic        fr;
    logic [COL_W-1:0] a0, a1, a2;
    logic [41:0] cd;
    logic [15:0] sf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [15:0] d, input logic fs);
    @(negedge clk);
    chipselect = 1; write = 1; address = a; writedata = d; frame_start = fs;
    @(posedge clk); #1;
    chipselect = 0; write = 0; frame_start = 0;
  endtask

  task automatic send_col(input int i);
    wr(0, 16'(i), 0); wr(0, 16'h1000 + 16'(i), 0);
    wr(0, 16'h2000 + 16'(i), 0); wr(0, 16'h0100, 0);
  endtask

  task automatic send_frame();
    for (int i = 0; i < NUM_COLS; i++) send_col(i);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  task automatic chk_roles(input string tag, input logic [1:0] rd, input logic [1:0] wrb,
                           input logic fr, input logic [DROP_W-1:0] dr);
    chk({tag, ".rd_bank"}, 64'(rd_bank), 64'(rd));
    chk({tag, ".wr_bank"}, 64'(wr_bank), 64'(wrb));
    chk({tag, ".frame_ready"}, 64'(frame_ready), 64'(fr));
    chk({tag, ".dropped"}, 64'(dropped_frames), 64'(dr));
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{0,0,16'hFFFF,0, 3'b000,0,1,0, 5,0,0, 42'h0, 16'h0};
    vt[1]  = '{0,0,16'h0000,1, 3'b000,0,1,0, 5,0,0, 42'h0, 16'h0};
    vt[2]  = '{1,0,16'h0123,0, 3'b000,0,1,0, 5,0,0, 42'h0, 16'h0};
    vt[3]  = '{1,0,16'hAAAA,0, 3'b000,0,1,0, 5,0,0, 42'h0, 16'h0};
    vt[4]  = '{1,0,16'h5555,0, 3'b000,0,1,0, 5,0,0, 42'h0, 16'h0};
    vt[5]  = '{1,0,16'h0200,0, 3'b010,0,1,0, 5,0,0, {16'h5555,16'hAAAA,10'h123}, 16'h0200};
    vt[6]  = '{0,0,16'h0000,0, 3'b000,0,1,0, 5,0,0, {16'h5555,16'hAAAA,10'h123}, 16'h0200};
    vt[7]  = '{1,0,16'hFFFF,0, 3'b000,0,1,0, 5,0,0, {16'h5555,16'hAAAA,10'h123}, 16'h0200};
    vt[8]  = '{1,0,16'h1234,0, 3'b000,0,1,0, 5,0,0, {16'h5555,16'hAAAA,10'h123}, 16'h0200};
    vt[9]  = '{1,0,16'h8001,0, 3'b000,0,1,0, 5,0,0, {16'h5555,16'hAAAA,10'h123}, 16'h0200};
    vt[10] = '{1,0,16'h7FFF,0, 3'b010,0,1,0, 5,1,0, {16'h8001,16'h1234,10'h3FF}, 16'h7FFF};
    vt[11] = '{0,0,16'h0000,0, 3'b000,0,1,0, 5,0,0, {16'h8001,16'h1234,10'h3FF}, 16'h7FFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_roles("reset", 0, 1, 0, 0);
    chk("reset.bank_we", 64'(bank_we), 0);
    chk("reset.coldata", 64'(wr_coldata), 0);
    @(negedge clk); reset = 0;

    // Single-column vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chipselect = vt[i].cs; write = 1; address = vt[i].a;
      writedata = vt[i].d; frame_start = vt[i].fs;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.bank_we", i), 64'(bank_we), 64'(vt[i].we));
      chk($sformatf("vec%0d.rd_bank", i), 64'(rd_bank), 64'(vt[i].rd));
      chk($sformatf("vec%0d.wr_bank", i), 64'(wr_bank), 64'(vt[i].wr));
      chk($sformatf("vec%0d.frame_ready", i), 64'(frame_ready), 64'(vt[i].fr));
      chk($sformatf("vec%0d.addr0", i), 64'(bank_addr[0 +: COL_W]), 64'(vt[i].a0));
      chk($sformatf("vec%0d.addr1", i), 64'(bank_addr[COL_W +: COL_W]), 64'(vt[i].a1));
      chk($sformatf("vec%0d.addr2", i), 64'(bank_addr[2*COL_W +: COL_W]), 64'(vt[i].a2));
      chk($sformatf("vec%0d.coldata", i), 64'(wr_coldata), 64'(vt[i].cd));
      chk($sformatf("vec%0d.sfdata", i), 64'(wr_sfdata), 64'(vt[i].sf));
      chipselect = 0; write = 0; frame_start = 0;
    end

    // Resync to column 0, then one full frame and a swap
    wr(1, 16'h0001, 0);
    send_frame();
    chk_roles("frame1", 0, 2, 1, 0);
    @(negedge clk); frame_start = 1;
    @(posedge clk); #1; frame_start = 0;
    chk_roles("swap", 1, 2, 0, 0);

    // Two frames without a swap: one dropped
    do_reset();
    send_frame();
    send_frame();
    chk_roles("drop", 0, 1, 1, 1);
    wr(1, 16'h0002, 0);
    chk_roles("clear", 0, 1, 1, 0);

    // Async reset mid-frame
    send_col(0); send_col(1);
    @(negedge clk); #3; reset = 1; #1;
    chk_roles("async", 0, 1, 0, 0);
    chk("async.coldata", 64'(wr_coldata), 0);
    @(negedge clk); reset = 0;

    // Completion coinciding with frame_start
    for (int i = 0; i < NUM_COLS - 1; i++) send_col(i);
    wr(0, 16'h0001, 0); wr(0, 16'h0002, 0); wr(0, 16'h0003, 0);
    wr(0, 16'h0004, 1);
    chk_roles("simul", 1, 0, 0, 0);

    // Resync discards partial column
    do_reset();
    wr(0, 16'h0111, 0); wr(0, 16'h2222, 0);
    wr(1, 16'h0001, 0);
    chk("resync.ctrl_we", 64'(bank_we), 0);
    wr(0, 16'h0155, 0);
    chk("resync.w0_we", 64'(bank_we), 0);
    wr(0, 16'h3333, 0);
    chk("resync.w1_we", 64'(bank_we), 0);
    wr(0, 16'h4444, 0);
    chk("resync.w2_we", 64'(bank_we), 0);
    wr(0, 16'h0009, 0);
    chk("resync.we", 64'(bank_we), 64'(3'b010));
    chk("resync.addr1", 64'(bank_addr[COL_W +: COL_W]), 0);
    chk("resync.coldata", 64'(wr_coldata), 64'({16'h4444, 16'h3333, 10'h155}));
    chk("resync.sfdata", 64'(wr_sfdata), 64'(16'h0009));
    @(posedge clk); #1;
    chk("resync.we_off", 64'(bank_we), 0);
    chk("resync.addr0", 64'(bank_addr[0 +: COL_W]), 64'(rd_col));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/column_bank_scheduler.md
Name: column_bank_scheduler

Overview:
Controller for the triple-buffered column store feeding the raycaster's VGA column decoder. It assembles the four 16-bit Avalon words of each column into one column record and steps the write column index. It also rotates three column banks between write, pending and read roles so that the display pipeline swaps banks only at a frame boundary. It drives per-bank write enables and addresses, and the bank-select used by the pixel pipeline.

Parameters:
NUM_COLS, 640, columns per frame; the last index is NUM_COLS-1.
COL_W, 10, column index width.
DROP_W, 8, width of the dropped-frame counter.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high
chipselect  in  1  Avalon chip select
write  in  1  Avalon write strobe; a word is accepted when chipselect && write
address  in  1  0 = column data word, 1 = control word
writedata  in  16  Avalon write data
frame_start  in  1  one-cycle pulse from the display timing at the start of vertical blank (vcount==480)
rd_col  in  COL_W  column index requested by the pixel pipeline
bank_we  out  3  one-hot write enable per bank
bank_addr  out  3*COL_W  per-bank address; bank k occupies bits [k*COL_W +: COL_W]
wr_coldata  out  42  column record to write: {w2, w1, w0[9:0]}
wr_sfdata  out  16  scale factor to write (the 4th word)
rd_bank  out  2  bank the pixel pipeline reads
wr_bank  out  2  bank currently being filled
frame_ready  out  1  a completed frame is pending
dropped_frames  out  DROP_W  saturating count of overwritten pending frames

Behaviour:
- Reset values: bank_we=0, wr_coldata=0, wr_sfdata=0, rd_bank=0, wr_bank=1, pend_bank=2, frame_ready=0, dropped_frames=0, word FSM=W0, wr_col=0.
- Bank roles: rd_bank, wr_bank and pend_bank always hold the distinct values {0,1,2}. The free bank for the given roles is 3^a^b.
- Word FSM (address 0 accepts only): W0 latches writedata[9:0] -> W1 latches w1 -> W2 latches w2 -> W3.
- In W3: register wr_coldata={w2,w1,w0}, wr_sfdata=writedata, wr_addr=wr_col. Next cycle bank_we[wr_bank]=1 for exactly one cycle. FSM returns to W0.
  - Latency: write pulse 1 cycle after the 4th word is accepted.
- Column step on the W3 accept: if wr_col != NUM_COLS-1, wr_col+1; else wr_col=0 and frame completes, using the wr_bank value captured for that write.
- Frame completion, no simultaneous swap:
  - frame_ready=0: pend_bank<=wr_bank, wr_bank<=3^wr_bank^rd_bank, frame_ready<=1.
  - frame_ready=1: swap roles of wr_bank and pend_bank (old pending is discarded and reused for writing). dropped_frames+1, saturating at all-ones.
- Swap on frame_start, no simultaneous completion: if frame_ready, rd_bank<=pend_bank, pend_bank<=old rd_bank, frame_ready<=0. Otherwise no change.
- Completion and frame_start in the same cycle: rd_bank<=completing bank. wr_bank<=old rd_bank. pend_bank<=the remaining bank. frame_ready<=0. If frame_ready was 1, dropped_frames+1.
- Role changes take effect on the next edge. The pending bank_we pulse targets the bank captured at W3, never the new rd_bank.
- bank_addr mux (combinational from registered state):
  - bank k: wr_addr when bank_we[k];
  - else rd_col when k==rd_bank;
  - else 0.
- Control word (address 1): writedata[0]=1 resyncs: FSM<=W0, partial words discarded, wr_col<=0, no bank_we, roles unchanged. writedata[1]=1 clears dropped_frames. Both bits may be set together.
- Address-1 writes do not advance the word FSM.
- Resync arriving in the cycle a bank_we pulse is already scheduled: the pulse still completes.
- Writes with chipselect=0 are ignored. Back-to-back writes on consecutive cycles are accepted.
- Async reset mid-frame returns every register to its reset value immediately. The partial frame is lost.

Test Plan:
- Reset -> rd_bank=0, wr_bank=1, bank_we=0, frame_ready=0, dropped_frames=0.
- Words 0x0123, 0xAAAA, 0x5555, 0x0200 to address 0 -> next cycle bank_we=3'b010, bank 1 addr=0, wr_coldata={16'h5555,16'hAAAA,10'h123}, wr_sfdata=0x0200; the cycle after, bank_we=0 and bank 0 addr=rd_col.
- 2560 words (640 columns), no frame_start -> frame_ready=1, wr_bank=2. Then frame_start pulse -> rd_bank=1, wr_bank=2, frame_ready=0.
- Two full frames, no frame_start -> after the second, dropped_frames=1, frame_ready=1, pend_bank=2, wr_bank=1, rd_bank=0.
- Last column's 4th word accepted in the same cycle as frame_start, frame_ready=0 -> rd_bank=1, wr_bank=0, frame_ready=0, dropped_frames unchanged.
- Two data words, then control 0x0001, then 4 new words -> one write only, to address 0, containing the new words. Control 0x0002 clears dropped_frames to 0.
